// File: rtl/veririsc_controller.sv
// veririsc_controller
//   Eight-phase instruction sequencer for the VeriRISC core. It decodes the
//   current phase and the IR opcode into every datapath and memory strobe.
//
//   Optional feature (define VERIRISC_CTRL_RESUME_EN):
//     adds input `resume`, which leaves HALTED and returns to INST_ADDR.
//
//   Ports:
//     clk     in   system clock, rising edge
//     rst_n   in   asynchronous active-low reset
//     opcode  in   IR opcode (OPW bits)
//     zero    in   accumulator-is-zero flag
//     resume  in   leave HALTED (only with VERIRISC_CTRL_RESUME_EN)
//     sel     out  address mux select, 1 = PC, 0 = IR operand
//     rd, wr  out  memory read / write enables
//     ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt   out  datapath strobes
//     phase   out  current state encoding
//
//   state      | meaning
//   INST_ADDR  | PC drives the memory address
//   INST_FETCH | instruction read from memory
//   INST_LOAD  | instruction loaded into IR
//   IDLE       | IR load held, opcode now stable
//   OP_ADDR    | PC increments; HLT diverts to HALTED
//   OP_FETCH   | operand read for ALU ops
//   ALU_OP     | SKZ skip, JMP load, STO drives bus
//   STORE      | accumulator load or memory write
//   HALTED     | core stopped
module veririsc_controller #(
  parameter int OPW = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
`ifdef VERIRISC_CTRL_RESUME_EN
  input  logic           resume,
`endif
  output logic           sel,
  output logic           rd,
  output logic           wr,
  output logic           ld_ir,
  output logic           ld_ac,
  output logic           ld_pc,
  output logic           inc_pc,
  output logic           data_e,
  output logic           halt,
  output logic [3:0]     phase
);

  typedef enum logic [3:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    IDLE       = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    HALTED     = 4'd8
  } state_t;

  localparam logic [OPW-1:0] OP_HLT = OPW'(0);
  localparam logic [OPW-1:0] OP_SKZ = OPW'(1);
  localparam logic [OPW-1:0] OP_ADD = OPW'(2);
  localparam logic [OPW-1:0] OP_AND = OPW'(3);
  localparam logic [OPW-1:0] OP_XOR = OPW'(4);
  localparam logic [OPW-1:0] OP_LDA = OPW'(5);
  localparam logic [OPW-1:0] OP_STO = OPW'(6);
  localparam logic [OPW-1:0] OP_JMP = OPW'(7);

  state_t state_q, state_d;

  logic is_hlt, is_skz, is_sto, is_jmp, is_aluop;

  assign is_hlt   = (opcode == OP_HLT);
  assign is_skz   = (opcode == OP_SKZ);
  assign is_sto   = (opcode == OP_STO);
  assign is_jmp   = (opcode == OP_JMP);
  assign is_aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                    (opcode == OP_XOR) || (opcode == OP_LDA);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= INST_ADDR;
    else        state_q <= state_d;
  end

  // Strobes are pure decodes of state, so reset clears wr (and every other
  // strobe) as soon as rst_n falls, without waiting for an edge.
  always_comb begin
    state_d = INST_ADDR;
    sel     = 1'b0;
    rd      = 1'b0;
    wr      = 1'b0;
    ld_ir   = 1'b0;
    ld_ac   = 1'b0;
    ld_pc   = 1'b0;
    inc_pc  = 1'b0;
    data_e  = 1'b0;
    halt    = 1'b0;
    case (state_q)
      INST_ADDR: begin
        state_d = INST_FETCH;
        sel     = 1'b1;
      end
      INST_FETCH: begin
        state_d = INST_LOAD;
        sel     = 1'b1;
        rd      = 1'b1;
      end
      INST_LOAD: begin
        state_d = IDLE;
        sel     = 1'b1;
        rd      = 1'b1;
        ld_ir   = 1'b1;
      end
      IDLE: begin
        state_d = OP_ADDR;
        sel     = 1'b1;
        rd      = 1'b1;
        ld_ir   = 1'b1;
      end
      OP_ADDR: begin
        state_d = is_hlt ? HALTED : OP_FETCH;
        inc_pc  = 1'b1;
        halt    = is_hlt;
      end
      OP_FETCH: begin
        state_d = ALU_OP;
        rd      = is_aluop;
      end
      ALU_OP: begin
        state_d = STORE;
        rd      = is_aluop;
        inc_pc  = is_skz && zero;
        ld_pc   = is_jmp;
        data_e  = is_sto;
      end
      STORE: begin
        state_d = INST_ADDR;
        rd      = is_aluop;
        ld_ac   = is_aluop;
        inc_pc  = is_jmp;
        ld_pc   = is_jmp;
        wr      = is_sto;
        data_e  = is_sto;
      end
      HALTED: begin
`ifdef VERIRISC_CTRL_RESUME_EN
        state_d = resume ? INST_ADDR : HALTED;
`else
        state_d = HALTED;
`endif
        halt    = 1'b1;
      end
      default: state_d = INST_ADDR;
    endcase
  end

  assign phase = state_q;

endmodule
